// File: rtl/square_plot_arbiter.sv
// Shares one solid-square plotting engine between NUM_REQ requesters and streams one pixel per clock.
// Define FIXED_PRI_EN for lowest-index-wins arbitration; the default build is round-robin.
//
// state | meaning
// IDLE  | waiting for a request; on a request a winner is chosen and pixel 0 is issued
// DRAW  | one pixel per clock, counter holds the index of the pixel on the outputs
// DONE  | square finished, ack pulse is visible to the granted requester
module square_plot_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int SIDE_LOG2 = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [8*NUM_REQ-1:0]   x_in,
    input  logic [7*NUM_REQ-1:0]   y_in,
    input  logic [3*NUM_REQ-1:0]   colour_in,
    output logic [7:0]             x_out,
    output logic [6:0]             y_out,
    output logic [2:0]             colour_out,
    output logic                   plot,
    output logic                   busy,
    output logic [NUM_REQ-1:0]     ack,
    output logic [2:0]             grant_id
);

    localparam int CNT_W = 2 * SIDE_LOG2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DRAW = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state, state_n;
    logic [CNT_W-1:0]   cnt, cnt_n, cnt_inc;
    logic [7:0]         base_x, base_x_n;
    logic [6:0]         base_y, base_y_n;
    logic [2:0]         base_c, base_c_n;
    logic [7:0]         x_n;
    logic [6:0]         y_n;
    logic [2:0]         c_n;
    logic               plot_n;
    logic               busy_n;
    logic [NUM_REQ-1:0] ack_n;
    logic [2:0]         grant_n;
    logic [2:0]         win;
    logic               found;
    int                 scan_base;
    int                 idx;
    int                 win_i;

`ifndef FIXED_PRI_EN
    logic [2:0]         ptr, ptr_n;
`endif

    function automatic logic [7:0] col_off(input logic [CNT_W-1:0] c);
        col_off = 8'(c[SIDE_LOG2-1:0]);
    endfunction

    function automatic logic [6:0] row_off(input logic [CNT_W-1:0] c);
        row_off = 7'(c[CNT_W-1:SIDE_LOG2]);
    endfunction

    // Winner is the first asserted request scanning upward from the scan base, wrapping.
    always_comb begin
        win   = '0;
        found = 1'b0;
        idx   = 0;
`ifdef FIXED_PRI_EN
        scan_base = 0;
`else
        scan_base = int'(ptr);
`endif
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = scan_base + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!found && req[idx]) begin
                found = 1'b1;
                win   = 3'(idx);
            end
        end
    end

    assign win_i   = int'(win);
    assign cnt_inc = cnt + 1'b1;

    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        base_x_n = base_x;
        base_y_n = base_y;
        base_c_n = base_c;
        x_n      = x_out;
        y_n      = y_out;
        c_n      = colour_out;
        plot_n   = 1'b0;
        ack_n    = '0;
        grant_n  = grant_id;
`ifndef FIXED_PRI_EN
        ptr_n    = ptr;
`endif
        case (state)
            IDLE: begin
                if (found) begin
                    base_x_n = x_in[8*win_i +: 8];
                    base_y_n = y_in[7*win_i +: 7];
                    base_c_n = colour_in[3*win_i +: 3];
                    grant_n  = win;
                    cnt_n    = '0;
                    // Pixel 0 sits at the base itself, so it goes straight out from the inputs.
                    x_n      = x_in[8*win_i +: 8];
                    y_n      = y_in[7*win_i +: 7];
                    c_n      = colour_in[3*win_i +: 3];
                    plot_n   = 1'b1;
                    state_n  = DRAW;
                end
            end
            DRAW: begin
                if (&cnt) begin
                    for (int i = 0; i < NUM_REQ; i++) begin
                        ack_n[i] = (int'(grant_id) == i);
                    end
                    state_n = DONE;
                end else begin
                    cnt_n  = cnt_inc;
                    x_n    = base_x + col_off(cnt_inc);
                    y_n    = base_y + row_off(cnt_inc);
                    c_n    = base_c;
                    plot_n = 1'b1;
                end
            end
            DONE: begin
`ifndef FIXED_PRI_EN
                if (int'(grant_id) >= NUM_REQ - 1) begin
                    ptr_n = '0;
                end else begin
                    ptr_n = grant_id + 3'd1;
                end
`endif
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
        busy_n = (state_n != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            base_x     <= '0;
            base_y     <= '0;
            base_c     <= '0;
            x_out      <= '0;
            y_out      <= '0;
            colour_out <= '0;
            plot       <= 1'b0;
            busy       <= 1'b0;
            ack        <= '0;
            grant_id   <= '0;
`ifndef FIXED_PRI_EN
            ptr        <= '0;
`endif
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            base_x     <= base_x_n;
            base_y     <= base_y_n;
            base_c     <= base_c_n;
            x_out      <= x_n;
            y_out      <= y_n;
            colour_out <= c_n;
            plot       <= plot_n;
            busy       <= busy_n;
            ack        <= ack_n;
            grant_id   <= grant_n;
`ifndef FIXED_PRI_EN
            ptr        <= ptr_n;
`endif
        end
    end

endmodule
